tlp2mdio: RTL and testbench
===========================

Name: tlp2mdio

Overview:
- Passive tap on the 64-bit TRN receive interface of the PCIe endpoint, in the trn_clk domain.
- Detects 1-DW memory writes to the MDIO access register in the configured BAR.
- Extracts the 32-bit host command word and presents it on acc_data.
- Asserts a stretched acc_en strobe that the MDIO host-interface FSM double-registers into host_clk.
- Never drives trn_rdst_rdy_n; the main RX engine owns flow control.

Parameters:
- BAR_HIT_IDX, 0, index of trn_rbar_hit_n bit that must be low (active) for a match.
- MDIO_REG_OFFSET, 10'h010, DW offset in the BAR: address bits [11:2] that select the MDIO access register.
- ACC_EN_CYCLES, 8, trn_clk cycles acc_en stays high per accepted write. Legal range 4..255.

Ports:
- trn_clk  in  1  PCIe user clock
- reset_n  in  1  asynchronous active-low reset
- trn_rd  in  64  RX data; DW0 in [63:32] on the first beat
- trn_rrem_n  in  8  RX remainder; 8'h00 = both DWs valid, 8'h0F = upper DW only
- trn_rsof_n  in  1  start of TLP, active low
- trn_reof_n  in  1  end of TLP, active low
- trn_rsrc_rdy_n  in  1  source ready, active low
- trn_rdst_rdy_n  in  1  destination ready (observed only), active low
- trn_rsrc_dsc_n  in  1  source discontinue, active low
- trn_rbar_hit_n  in  7  BAR hit, active low
- acc_data  out  32  last accepted command word: [27:26] opcode, [25:16] addr, [15:0] data
- acc_en  out  1  stretched strobe, ACC_EN_CYCLES long
- acc_drop  out  1  1-cycle pulse when a matching write is ignored because acc_en is still high

Behaviour:
- Beat definition: a beat is valid only when trn_rsrc_rdy_n == 0 and trn_rdst_rdy_n == 0. Non-valid cycles hold all state.
- Reset (async, reset_n == 0): acc_data = 32'h0, acc_en = 0, acc_drop = 0, FSM = S_IDLE, stretch counter = 0.
- S_IDLE: on a valid beat with trn_rsof_n == 0, capture the header.
  - hdr_ok = fmt[62:61] == 2'b10, type[60:56] == 5'b00000, length[41:32] == 10'd1, trn_rbar_hit_n[BAR_HIT_IDX] == 0.
  - hdr_ok → S_ADDR. Otherwise → S_SKIP.
  - If trn_reof_n == 0 on the same beat (malformed), stay in S_IDLE.
- S_ADDR: on the next valid beat, address DW = trn_rd[63:32] and payload = trn_rd[31:0].
  - Match = address[11:2] == MDIO_REG_OFFSET, trn_reof_n == 0, and trn_rrem_n == 8'h00.
  - Match → accept. Always → S_IDLE.
  - Beat with trn_reof_n == 1 → S_SKIP, no accept.
- S_SKIP: return to S_IDLE on a valid beat with trn_reof_n == 0.
- Discontinue: trn_rsrc_dsc_n == 0 in any state aborts the TLP.
  - FSM → S_IDLE; no accept even if the same beat carries eof.
- Accept, when acc_en == 0:
  - acc_data <= byte-swapped payload {p[7:0], p[15:8], p[23:16], p[31:24]} (little-endian PCIe payload → host word).
  - acc_en <= 1 on the next cycle; counter loads ACC_EN_CYCLES-1.
  - acc_en drops after exactly ACC_EN_CYCLES cycles high.
  - Latency: eof beat edge → acc_en high = 1 cycle; acc_data is valid in the same cycle acc_en rises.
- Accept while acc_en == 1: acc_data is unchanged, acc_en is not retriggered, acc_drop pulses for 1 cycle.
- acc_data stays stable from acc_en rise until the next accepted write; software issues one command per completion interrupt.
- Non-matching TLPs of any kind, including 4-DW-header MWr (fmt 2'b11), MRd, and completions, produce no output activity.
- Back-to-back TLPs: sof on the beat immediately after eof is decoded normally from S_IDLE.

Optional Feature:
- Macro: TLP2MDIO_BE_CHECK_EN.
- Defined: hdr_ok additionally requires first DW BE trn_rd[3:0] == 4'hF and last DW BE trn_rd[7:4] == 4'h0. Partial writes are skipped.
- Not defined: byte enables are ignored and any 1-DW MWr to the register is accepted.

Test Plan:
1. MWr 3DW, BAR0 hit, address 0x040, payload 32'h8A01_0014 → acc_data = 32'h1400_018A one cycle after the eof beat; acc_en high for exactly 8 cycles; acc_drop stays 0.
2. Same MWr to address 0x044, then an MRd to 0x040 → acc_en stays 0, acc_data unchanged.
3. Two matching MWr 3 cycles apart → the first is accepted; acc_drop pulses once on the second; acc_data keeps the first value.
4. Matching MWr with trn_rsrc_dsc_n low on the eof beat → no acc_en. A following valid MWr is accepted normally.
5. Matching MWr with trn_rsrc_rdy_n deasserted for 3 cycles between beats, and trn_rdst_rdy_n high for 2 cycles → accepted once with the correct data.
6. reset_n asserted mid-stretch (cycle 4) → acc_en and acc_data are 0 immediately. With TLP2MDIO_BE_CHECK_EN defined, a write with first BE 4'h3 is ignored; undefined, it is accepted.

Source files
------------

// File: rtl/tlp2mdio.sv
// Passive TRN RX tap: decodes 1-DW memory writes to the MDIO access register and
// presents the byte-swapped command with a stretched strobe. Optional: TLP2MDIO_BE_CHECK_EN.
module tlp2mdio #(
  parameter int unsigned BAR_HIT_IDX     = 0,
  parameter logic [9:0]  MDIO_REG_OFFSET = 10'h010,
  parameter int unsigned ACC_EN_CYCLES   = 8
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic        trn_rsrc_dsc_n,
  input  logic [6:0]  trn_rbar_hit_n,
  output logic [31:0] acc_data,
  output logic        acc_en,
  output logic        acc_drop
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_SKIP} state_t;

  localparam logic [2:0] BAR_SEL  = 3'(BAR_HIT_IDX);
  localparam logic [7:0] CNT_LOAD = 8'(ACC_EN_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       beat;
  logic       hdr_ok;
  logic       addr_match;
  logic       accept;
  logic       unused_bits;

  always_comb begin
    beat   = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    hdr_ok = (trn_rd[62:61] == 2'b10) && (trn_rd[60:56] == 5'b00000) &&
             (trn_rd[41:32] == 10'd1) && !trn_rbar_hit_n[BAR_SEL];
`ifdef TLP2MDIO_BE_CHECK_EN
    hdr_ok = hdr_ok && (trn_rd[3:0] == 4'hF) && (trn_rd[7:4] == 4'h0);
`endif
    addr_match = (trn_rd[43:34] == MDIO_REG_OFFSET) && !trn_reof_n &&
                 (trn_rrem_n == 8'h00);
    accept     = beat && trn_rsrc_dsc_n && (state == S_ADDR) && addr_match;
    unused_bits = ^{trn_rd[63], trn_rd[55:44], trn_rbar_hit_n};
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_data <= '0;
      acc_en   <= 1'b0;
      acc_drop <= 1'b0;
    end else begin
      acc_drop <= 1'b0;

      if (beat) begin
        if (!trn_rsrc_dsc_n) begin
          state <= S_IDLE;
        end else begin
          unique case (state)
            S_IDLE: begin
              // sof+eof on one beat is malformed: nothing to track
              if (!trn_rsof_n && trn_reof_n)
                state <= hdr_ok ? S_ADDR : S_SKIP;
            end
            S_ADDR: state <= trn_reof_n ? S_SKIP : S_IDLE;
            S_SKIP: if (!trn_reof_n) state <= S_IDLE;
            default: state <= S_IDLE;
          endcase
        end
      end

      if (accept && !acc_en) begin
        acc_data <= {trn_rd[7:0], trn_rd[15:8], trn_rd[23:16], trn_rd[31:24]};
        acc_en   <= 1'b1;
        cnt      <= CNT_LOAD;
      end else begin
        if (accept)
          acc_drop <= 1'b1;
        if (acc_en) begin
          if (cnt == 8'd0)
            acc_en <= 1'b0;
          else
            cnt <= cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlp2mdio.sv
// Scoreboard bench for tlp2mdio: randomized TLP traffic against a transaction-level
// model; a negedge monitor pops expected strobes/drops as the DUT presents them.
module tb_tlp2mdio;

  localparam int N = 8;
  localparam int K_MWR3 = 0, K_MWR4 = 1, K_MRD = 2, K_CPL = 3;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] trn_rd = '0;
  logic [7:0]  trn_rrem_n = '0;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rdst_rdy_n = 1'b0;
  logic        trn_rsrc_dsc_n = 1'b1;
  logic [6:0]  trn_rbar_hit_n = 7'h7F;
  logic [31:0] acc_data;
  logic        acc_en;
  logic        acc_drop;

  tlp2mdio #(.BAR_HIT_IDX(0), .MDIO_REG_OFFSET(10'h010), .ACC_EN_CYCLES(N)) dut (
    .trn_clk(trn_clk), .reset_n(reset_n), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
    .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rsrc_dsc_n(trn_rsrc_dsc_n),
    .trn_rbar_hit_n(trn_rbar_hit_n), .acc_data(acc_data), .acc_en(acc_en), .acc_drop(acc_drop)
  );

  always #5 trn_clk = ~trn_clk;

  int cyc = 0;
  always @(posedge trn_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          eidx;
  } exp_t;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] payload;
    logic [6:0]  bar;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [9:0]  len;
    int          dsc_beat;
  } tlp_t;

  exp_t acc_q[$];
  int   drop_q[$];
  int   busy_until = -1000;
  int   checks = 0;
  int   errors = 0;

  bit   rnd_stall = 1'b0;
  int   fix_src_gap = 0;
  int   fix_dst_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: one accepted register write, decided on whole-TLP fields.
  task automatic model_accept(input int eidx, input logic [31:0] p);
    exp_t e;
    if (eidx <= busy_until) begin
      drop_q.push_back(eidx);
    end else begin
      e.data = {<<8{p}};
      e.eidx = eidx;
      acc_q.push_back(e);
      busy_until = eidx + N;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge trn_clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] rrem, input logic sof,
                           input logic eof, input logic dsc, output int eidx);
    int sg, dg;
    sg = rnd_stall ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0) : fix_src_gap;
    dg = rnd_stall ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : fix_dst_gap;
    trn_rd = d;
    trn_rrem_n = rrem;
    trn_rsof_n = !sof;
    trn_reof_n = !eof;
    trn_rsrc_dsc_n = 1'b1;
    repeat (sg) begin
      trn_rsrc_rdy_n = 1'b1; trn_rdst_rdy_n = 1'b0;
      @(posedge trn_clk); #1;
    end
    repeat (dg) begin
      trn_rsrc_rdy_n = 1'b0; trn_rdst_rdy_n = 1'b1;
      @(posedge trn_clk); #1;
    end
    trn_rsrc_rdy_n = 1'b0;
    trn_rdst_rdy_n = 1'b0;
    trn_rsrc_dsc_n = !dsc;
    @(posedge trn_clk);
    #1;
    eidx = cyc;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
  endtask

  task automatic send_tlp(input tlp_t t, output int eidx);
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [31:0] dw0, dw1;
    logic [63:0] beats[$];
    logic [7:0]  rrems[$];
    bit          hit;
    bit          last, dsc;
    case (t.kind)
      K_MWR4:  begin fmt = 2'b11; typ = 5'b00000; end
      K_MRD:   begin fmt = 2'b00; typ = 5'b00000; end
      K_CPL:   begin fmt = 2'b10; typ = 5'b01010; end
      default: begin fmt = 2'b10; typ = 5'b00000; end
    endcase
    dw0 = {1'b0, fmt, typ, 14'h0, t.len};
    dw1 = {16'hBEEF, 8'($urandom), t.lbe, t.fbe};
    beats.push_back({dw0, dw1}); rrems.push_back(8'h00);
    case (t.kind)
      K_MWR4: begin
        beats.push_back({32'h0, t.addr}); rrems.push_back(8'h00);
        beats.push_back({t.payload, 32'($urandom)}); rrems.push_back(8'h0F);
      end
      K_MRD: begin
        beats.push_back({t.addr, 32'($urandom)}); rrems.push_back(8'h0F);
      end
      default: begin
        beats.push_back({(t.kind == K_CPL) ? 32'h0100_0004 : t.addr, t.payload});
        rrems.push_back(8'h00);
        if (t.len != 10'd1) begin
          beats.push_back({32'($urandom), 32'($urandom)}); rrems.push_back(8'h0F);
        end
      end
    endcase
    trn_rbar_hit_n = t.bar;
    eidx = cyc;
    for (int i = 0; i < beats.size(); i++) begin
      last = (i == beats.size() - 1);
      dsc  = (i == t.dsc_beat);
      send_beat(beats[i], rrems[i], i == 0, last, dsc, eidx);
      if (dsc) break;
    end
    hit = (t.kind == K_MWR3) && (t.len == 10'd1) && !t.bar[0] &&
          (t.addr[11:2] == 10'h010) && (t.dsc_beat < 0);
`ifdef TLP2MDIO_BE_CHECK_EN
    hit = hit && (t.fbe == 4'hF) && (t.lbe == 4'h0);
`endif
    if (hit)
      model_accept(eidx, t.payload);
  endtask

  function automatic tlp_t mwr(input logic [31:0] addr, input logic [31:0] p);
    tlp_t t;
    t.kind = K_MWR3; t.addr = addr; t.payload = p; t.bar = 7'h7E;
    t.fbe = 4'hF; t.lbe = 4'h0; t.len = 10'd1; t.dsc_beat = -1;
    return t;
  endfunction

  // Monitor / scoreboard
  logic [31:0] hold = '0;
  bit          prev_en = 1'b0;
  bit          measuring = 1'b0;
  int          hi = 0;

  always @(negedge trn_clk) begin
    exp_t e;
    if (!reset_n) begin
      hold = '0;
      measuring = 1'b0;
      prev_en = acc_en;
    end else begin
      if (acc_en && !prev_en) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL en_spurious actual=acc_en rose at cycle %0d required=no strobe", cyc);
        end else begin
          e = acc_q.pop_front();
          chk("acc_data_rise", acc_data, e.data);
          chk("en_latency", 32'(cyc), 32'(e.eidx));
          hold = e.data;
        end
        measuring = 1'b1;
        hi = 0;
      end
      if (acc_en) hi++;
      else if (prev_en && measuring) begin
        chk("en_length", 32'(hi), 32'(N));
        measuring = 1'b0;
      end
      chk("data_hold", acc_data, hold);
      if (acc_drop) begin
        if (drop_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL drop_spurious actual=acc_drop high at cycle %0d required=low", cyc);
        end else begin
          chk("drop_time", 32'(cyc), 32'(drop_q.pop_front()));
        end
      end
      prev_en = acc_en;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tlp_t t;
    int   e, r;
    bit   seen;

    idle(3);
    #1;
    chk("reset_acc_en", 32'(acc_en), 32'h0);
    chk("reset_acc_data", acc_data, 32'h0);
    chk("reset_acc_drop", 32'(acc_drop), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // 1: basic accept
    send_tlp(mwr(32'h0000_0040, 32'h8A01_0014), e);
    chk("t1_en", 32'(acc_en), 32'h1);
    chk("t1_data", acc_data, 32'h1400_018A);
    idle(N + 2);

    // 2: wrong address, then MRd to the register
    send_tlp(mwr(32'h0000_0044, 32'h1111_2222), e);
    t = mwr(32'h0000_0040, 32'h0);
    t.kind = K_MRD;
    send_tlp(t, e);
    idle(N + 2);
    chk("t2_en", 32'(acc_en), 32'h0);
    chk("t2_data", acc_data, 32'h1400_018A);

    // 3: second write lands while strobe still high
    send_tlp(mwr(32'h0000_0040, 32'hA5A5_0001), e);
    idle(3);
    send_tlp(mwr(32'h0000_0040, 32'h5A5A_0002), e);
    idle(N + 2);
    chk("t3_data", acc_data, 32'h0100_A5A5);

    // 4: discontinue on the eof beat, then a clean write
    t = mwr(32'h0000_0040, 32'hDEAD_0003);
    t.dsc_beat = 1;
    send_tlp(t, e);
    send_tlp(mwr(32'h0000_1040, 32'h0403_0201), e);
    idle(N + 2);
    chk("t4_data", acc_data, 32'h0102_0304);

    // 5: source and destination stalls
    fix_src_gap = 3;
    fix_dst_gap = 2;
    send_tlp(mwr(32'h0000_0040, 32'h7766_5544), e);
    fix_src_gap = 0;
    fix_dst_gap = 0;
    idle(N + 2);
    chk("t5_data", acc_data, 32'h4455_6677);

    // 6: reset during the stretch, then partial byte enables
    send_tlp(mwr(32'h0000_0040, 32'h1234_5678), e);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (acc_en) begin seen = 1'b1; break; end
      idle(1);
    end
    chk("t6_en_seen", 32'(seen), 32'h1);
    idle(3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_en", 32'(acc_en), 32'h0);
    chk("t6_rst_data", acc_data, 32'h0);
    busy_until = -1000;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    t = mwr(32'h0000_0040, 32'hCAFE_F00D);
    t.fbe = 4'h3;
    send_tlp(t, e);
`ifdef TLP2MDIO_BE_CHECK_EN
    chk("t6_be_en", 32'(acc_en), 32'h0);
`else
    chk("t6_be_en", 32'(acc_en), 32'h1);
`endif
    idle(N + 2);

    // Random traffic
    rnd_stall = 1'b1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      t = mwr($urandom_range(0, 4) != 0 ? {20'($urandom), 12'h040} : {30'($urandom), 2'b00},
              $urandom);
      t.kind = (r == 6) ? K_MWR4 : (r == 7) ? K_MRD : (r == 8) ? K_CPL : K_MWR3;
      if ($urandom_range(0, 4) == 0) t.bar = 7'($urandom);
      if ($urandom_range(0, 4) == 0) t.fbe = 4'($urandom);
      if ($urandom_range(0, 6) == 0) t.lbe = 4'($urandom);
      if ($urandom_range(0, 6) == 0) t.len = 10'd2;
      if ($urandom_range(0, 9) == 0) t.dsc_beat = $urandom_range(0, 1);
      send_tlp(t, e);
      idle($urandom_range(0, 12));
    end
    rnd_stall = 1'b0;

    idle(N + 5);
    chk("acc_q_empty", 32'(acc_q.size()), 32'h0);
    chk("drop_q_empty", 32'(drop_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
